// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit direction counters and resolve-side statistics.
// Fetch lookup is purely combinational; execute feedback updates the table on the clock edge.
module branch_predictor_btb #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_f,
  output logic             hit_f,
  output logic             pred_taken_f,
  output logic [XLEN-1:0]  pred_target_f,
  input  logic             upd_valid_e,
  input  logic [XLEN-1:0]  upd_pc_e,
  input  logic             upd_is_jump_e,
  input  logic             upd_taken_e,
  input  logic [XLEN-1:0]  upd_target_e,
  input  logic             upd_pred_taken_e,
  input  logic [XLEN-1:0]  upd_pred_target_e,
  output logic             mispredict_e,
  output logic [XLEN-1:0]  redirect_pc_e,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [ENTRIES-1:0] jmp;
  logic [TAG_W-1:0]   tag_mem    [ENTRIES];
  logic [XLEN-1:0]    target_mem [ENTRIES];
  logic [1:0]         ctr_mem    [ENTRIES];

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  // Fetch-side lookup
  logic [IDX_W-1:0] idx_f;
  logic [TAG_W-1:0] tag_f;
  logic [XLEN-1:0]  seq_f;

  assign idx_f         = pc_f[IDX_W+1:2];
  assign tag_f         = pc_f[XLEN-1:IDX_W+2];
  assign seq_f         = pc_f + XLEN'(4);
  assign hit_f         = valid[idx_f] && (tag_mem[idx_f] == tag_f);
  assign pred_taken_f  = hit_f && (jmp[idx_f] || ctr_mem[idx_f][1]);
  assign pred_target_f = pred_taken_f ? target_mem[idx_f] : seq_f;

  // Execute-side resolve
  logic [IDX_W-1:0] idx_u;
  logic [TAG_W-1:0] tag_u;
  logic             hit_u;
  logic             take_u;
  logic             wrong;
  logic             unused_pc_lsbs;

  assign idx_u  = upd_pc_e[IDX_W+1:2];
  assign tag_u  = upd_pc_e[XLEN-1:IDX_W+2];
  assign hit_u  = valid[idx_u] && (tag_mem[idx_u] == tag_u);
  // Jumps train the taken path even if the execute stage reports otherwise.
  assign take_u = upd_taken_e | upd_is_jump_e;
  assign wrong  = (upd_taken_e != upd_pred_taken_e) ||
                  (upd_taken_e && (upd_target_e != upd_pred_target_e));

  assign mispredict_e   = upd_valid_e && wrong;
  assign redirect_pc_e  = !upd_valid_e ? '0 :
                          upd_taken_e  ? upd_target_e : upd_pc_e + XLEN'(4);
  assign unused_pc_lsbs = ^{pc_f[1:0], upd_pc_e[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      jmp   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        ctr_mem[i]    <= 2'b01;
      end
    end else if (upd_valid_e) begin
      if (hit_u) begin
        if (take_u) begin
          ctr_mem[idx_u]    <= sat_inc2(ctr_mem[idx_u]);
          target_mem[idx_u] <= upd_target_e;
          jmp[idx_u]        <= upd_is_jump_e;
        end else begin
          ctr_mem[idx_u] <= sat_dec2(ctr_mem[idx_u]);
        end
      end else if (take_u) begin
        valid[idx_u]      <= 1'b1;
        tag_mem[idx_u]    <= tag_u;
        target_mem[idx_u] <= upd_target_e;
        jmp[idx_u]        <= upd_is_jump_e;
        ctr_mem[idx_u]    <= upd_is_jump_e ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (upd_valid_e) begin
      branch_cnt     <= sat_cnt_inc(branch_cnt, 1'b1);
      mispredict_cnt <= sat_cnt_inc(mispredict_cnt, wrong);
    end
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: directed vector table, randomized run against a table model,
// mid-update reset and counter saturation on a narrow-counter instance.
module tb_branch_predictor_btb;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_f = '0;
  logic        hit_f, pred_taken_f;
  logic [31:0] pred_target_f;
  logic        uv = 1'b0, ujmp = 1'b0, utk = 1'b0, uptk = 1'b0;
  logic [31:0] upc = '0, utgt = '0, uptgt = '0;
  logic        mis;
  logic [31:0] red;
  logic [31:0] bcnt, mcnt;

  // narrow-counter instance for saturation
  logic        s_uv = 1'b0, s_hit, s_ptk, s_mis;
  logic [31:0] s_ptgt, s_red;
  logic [1:0]  s_bcnt, s_mcnt;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  branch_predictor_btb #(.XLEN(32), .ENTRIES(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .pc_f(pc_f), .hit_f(hit_f), .pred_taken_f(pred_taken_f),
    .pred_target_f(pred_target_f), .upd_valid_e(uv), .upd_pc_e(upc), .upd_is_jump_e(ujmp),
    .upd_taken_e(utk), .upd_target_e(utgt), .upd_pred_taken_e(uptk),
    .upd_pred_target_e(uptgt), .mispredict_e(mis), .redirect_pc_e(red),
    .branch_cnt(bcnt), .mispredict_cnt(mcnt));

  branch_predictor_btb #(.XLEN(32), .ENTRIES(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .pc_f(32'h40), .hit_f(s_hit), .pred_taken_f(s_ptk),
    .pred_target_f(s_ptgt), .upd_valid_e(s_uv), .upd_pc_e(32'h40), .upd_is_jump_e(1'b0),
    .upd_taken_e(1'b1), .upd_target_e(32'h800), .upd_pred_taken_e(1'b0),
    .upd_pred_target_e(32'h44), .mispredict_e(s_mis), .redirect_pc_e(s_red),
    .branch_cnt(s_bcnt), .mispredict_cnt(s_mcnt));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model: 16-entry table from the behavioural rules ----------------
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_jmp   [16];
  longint      m_br, m_mis;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic mreset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1; m_jmp[i] = 0;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic mpredict(input logic [31:0] pc, output bit h, output bit t, output logic [31:0] g);
    int i;
    i = midx(pc);
    h = m_valid[i] && (m_tag[i] == (pc >> 6));
    t = h && (m_jmp[i] || m_ctr[i] >= 2);
    g = t ? m_tgt[i] : pc + 32'd4;
  endtask

  task automatic mupdate(input logic [31:0] pc, input bit j, input bit tk, input logic [31:0] tg,
                         input bit miss_flag);
    int i;
    bit h;
    i = midx(pc);
    h = m_valid[i] && (m_tag[i] == (pc >> 6));
    if (h && (tk || j)) begin
      m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3; m_tgt[i] = tg; m_jmp[i] = j;
    end else if (h) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end else if (tk || j) begin
      m_valid[i] = 1; m_tag[i] = pc >> 6; m_tgt[i] = tg; m_jmp[i] = j; m_ctr[i] = j ? 3 : 2;
    end
    m_br++;
    if (miss_flag) m_mis++;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] pc;
    logic        uv, jmp, tk;
    logic [31:0] upc, tgt;
    logic        ptk;
    logic [31:0] ptgt;
    logic        e_hit, e_ptk;
    logic [31:0] e_ptgt;
    logic        e_mis;
    logic [31:0] e_red;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic [31:0] pc, input logic uv_, input logic [31:0] upc_,
                              input logic j, input logic tk, input logic [31:0] tgt,
                              input logic ptk, input logic [31:0] ptgt, input logic eh,
                              input logic et, input logic [31:0] eg, input logic em,
                              input logic [31:0] er);
    vec_t v;
    v.pc = pc; v.uv = uv_; v.upc = upc_; v.jmp = j; v.tk = tk; v.tgt = tgt; v.ptk = ptk;
    v.ptgt = ptgt; v.e_hit = eh; v.e_ptk = et; v.e_ptgt = eg; v.e_mis = em; v.e_red = er;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_br, exp_mis;
    bit h, t, em;
    logic [31:0] g, er;

    //            pc           uv upc         j  tk tgt          ptk ptgt         hit tk  target       mis redirect
    vecs[0]  = mk(32'h100,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h104,     0, 32'h0);
    vecs[1]  = mk(32'h100,     1, 32'h100,   0, 1, 32'h80,    0, 32'h104,   0, 0, 32'h104,     1, 32'h80);
    vecs[2]  = mk(32'h100,     1, 32'h100,   0, 0, 32'h80,    1, 32'h80,    1, 1, 32'h80,      1, 32'h104);
    vecs[3]  = mk(32'h100,     1, 32'h100,   0, 0, 32'h80,    0, 32'h104,   1, 0, 32'h104,     0, 32'h104);
    vecs[4]  = mk(32'h100,     1, 32'h100,   0, 0, 32'h80,    0, 32'h104,   1, 0, 32'h104,     0, 32'h104);
    vecs[5]  = mk(32'h100,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     1, 0, 32'h104,     0, 32'h0);
    vecs[6]  = mk(32'h140,     1, 32'h140,   0, 1, 32'h200,   0, 32'h144,   0, 0, 32'h144,     1, 32'h200);
    vecs[7]  = mk(32'h100,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h104,     0, 32'h0);
    vecs[8]  = mk(32'h140,     0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     1, 1, 32'h200,     0, 32'h0);
    vecs[9]  = mk(32'h20,      1, 32'h20,    1, 1, 32'h400,   0, 32'h24,    0, 0, 32'h24,      1, 32'h400);
    vecs[10] = mk(32'h20,      1, 32'h20,    1, 1, 32'h400,   1, 32'h400,   1, 1, 32'h400,     0, 32'h400);
    vecs[11] = mk(32'h20,      1, 32'h20,    1, 1, 32'h480,   1, 32'h400,   1, 1, 32'h400,     1, 32'h480);
    vecs[12] = mk(32'h22,      0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     1, 1, 32'h480,     0, 32'h0);
    vecs[13] = mk(32'hFFFFFFFC,0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h0,       0, 32'h0);
    vecs[14] = mk(32'h10,      1, 32'h10,    0, 0, 32'h90,    0, 32'h14,    0, 0, 32'h14,      0, 32'h14);
    vecs[15] = mk(32'h10,      0, 32'h0,     0, 0, 32'h0,     0, 32'h0,     0, 0, 32'h14,      0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_bcnt", bcnt, 0);
    check("reset_mcnt", mcnt, 0);
    rst = 1'b1;

    exp_br = 0; exp_mis = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      pc_f = vecs[k].pc; uv = vecs[k].uv; upc = vecs[k].upc; ujmp = vecs[k].jmp;
      utk = vecs[k].tk; utgt = vecs[k].tgt; uptk = vecs[k].ptk; uptgt = vecs[k].ptgt;
      #1;
      check($sformatf("vec%0d_hit", k), hit_f, vecs[k].e_hit);
      check($sformatf("vec%0d_ptk", k), pred_taken_f, vecs[k].e_ptk);
      check($sformatf("vec%0d_ptgt", k), pred_target_f, vecs[k].e_ptgt);
      check($sformatf("vec%0d_mis", k), mis, vecs[k].e_mis);
      if (vecs[k].e_mis || !vecs[k].uv)
        check($sformatf("vec%0d_red", k), red, vecs[k].e_red);
      exp_br += int'(vecs[k].uv);
      exp_mis += int'(vecs[k].e_mis);
    end
    @(negedge clk);
    uv = 1'b0;
    #1;
    check("table_bcnt", bcnt, 64'(exp_br));
    check("table_mcnt", mcnt, 64'(exp_mis));

    // randomized run from a fresh reset
    rst = 1'b0;
    #1;
    check("rand_reset_hit", hit_f, 0);
    @(negedge clk);
    rst = 1'b1;
    mreset();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      pc_f = ({27'b0, 5'($urandom_range(0, 31))} + 32'h40) << 2 | 32'($urandom_range(0, 3));
      uv   = ($urandom_range(0, 3) != 0);
      upc  = ({27'b0, 5'($urandom_range(0, 31))} + 32'h40) << 2 | 32'($urandom_range(0, 3));
      ujmp = ($urandom_range(0, 4) == 0);
      utk  = ujmp ? 1'b1 : 1'($urandom_range(0, 1));
      utgt = 32'h1000 + (32'($urandom_range(0, 7)) << 4);
      if ($urandom_range(0, 1) == 1) begin
        mpredict(upc, h, t, g);
        uptk = t; uptgt = g;
      end else begin
        uptk = 1'($urandom_range(0, 1));
        uptgt = 32'h1000 + (32'($urandom_range(0, 7)) << 4);
      end
      #1;
      mpredict(pc_f, h, t, g);
      em = uv && ((utk != uptk) || (utk && (utgt != uptgt)));
      er = !uv ? 32'h0 : (utk ? utgt : upc + 32'd4);
      check("rand_hit", hit_f, h);
      check("rand_ptk", pred_taken_f, t);
      check("rand_ptgt", pred_target_f, g);
      check("rand_mis", mis, em);
      if (em || !uv) check("rand_red", red, er);
      @(posedge clk);
      if (uv) mupdate(upc, ujmp, utk, utgt, em);
    end
    @(negedge clk);
    uv = 1'b0;
    #1;
    check("rand_bcnt", bcnt, 64'(m_br));
    check("rand_mcnt", mcnt, 64'(m_mis));

    // reset asserted while an update is in flight
    upc = 32'h300; ujmp = 1'b1; utk = 1'b1; utgt = 32'h500; uptk = 1'b0; uptgt = 32'h304; uv = 1'b1;
    @(negedge clk);
    uv = 1'b1; upc = 32'h308; utgt = 32'h600; pc_f = 32'h300;
    #1;
    check("pre_rst_hit", hit_f, 1);
    check("pre_rst_ptgt", pred_target_f, 32'h500);
    rst = 1'b0;
    #1;
    check("rst_async_hit", hit_f, 0);
    check("rst_async_ptgt", pred_target_f, 32'h304);
    check("rst_async_bcnt", bcnt, 0);
    check("rst_async_mcnt", mcnt, 0);
    @(negedge clk);
    rst = 1'b1; uv = 1'b0; pc_f = 32'h308;
    #1;
    check("rst_nowrite_hit", hit_f, 0);
    check("rst_nowrite_bcnt", bcnt, 0);

    // counter saturation on the 2-bit instance
    @(negedge clk);
    s_uv = 1'b1;
    #1;
    check("sat_mis", s_mis, 1);
    repeat (5) @(negedge clk);
    s_uv = 1'b0;
    #1;
    check("sat_mcnt", s_mcnt, 2'b11);
    check("sat_bcnt", s_bcnt, 2'b11);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
